// File: rtl/alu_pkg.sv
// Shared definitions for the bitwise ALU slice and its accumulator stage.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT = 3'd3;
  localparam logic [OP_W-1:0] OP_SHL = 3'd4;
  localparam logic [OP_W-1:0] OP_SHR = 3'd5;
  localparam logic [OP_W-1:0] OP_ROL = 3'd6;
  localparam logic [OP_W-1:0] OP_ROR = 3'd7;

endpackage

// File: rtl/alu_accum_repeat_counter.sv
// Loadable down-counter holding the passes still to run; saturates at zero.
module repeat_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_q,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/alu_accum.sv
// Accumulator/flag stage behind the bitwise slice; repeats one latched opcode
// for count+1 cycles with a start/busy/done handshake.
module alu_accum
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op_in,
  input  logic [CNT_W-1:0] count_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] res_q,
  input  logic             res_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_cin,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] remaining;

  repeat_counter #(.CNT_W(CNT_W)) u_repeat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (count_in),
    .dec      (cnt_dec),
    .cnt_q    (remaining),
    .zero_c   (cnt_zero)
  );

  // Next-state and datapath; start outranks load, both ignored outside IDLE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = op_in;
          b_d      = b_in;
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end else if (load) begin
          acc_d  = load_data;
          zero_d = (load_data == '0);
        end
      end
      ST_RUN: begin
        acc_d   = res_q;
        carry_d = res_cout;
        zero_d  = (res_q == '0);
        if (cnt_zero) begin
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      b_q     <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      b_q     <= b_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign alu_a   = acc_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign alu_cin = carry_q;
  assign acc     = acc_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_alu_accum.sv
// Directed bench for alu_accum with a rotate-through-carry slice stub.
module tb_alu_accum;

  logic       clk, rst, start, load, res_cout;
  logic [2:0] op_in, count_in;
  logic [7:0] b_in, load_data, res_q;
  logic [7:0] alu_a, alu_b, acc;
  logic [2:0] alu_op;
  logic       alu_cin, carry, zero, busy, done;

  int checks = 0;
  int errors = 0;

  alu_accum #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op_in(op_in), .count_in(count_in),
    .b_in(b_in), .load(load), .load_data(load_data), .res_q(res_q),
    .res_cout(res_cout), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_cin(alu_cin), .acc(acc), .carry(carry), .zero(zero), .busy(busy),
    .done(done)
  );

  assign res_q    = {alu_a[6:0], alu_cin};
  assign res_cout = alu_a[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] d);
    load = 1'b1;
    load_data = d;
    tick();
    load = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [2:0] cnt, input logic [7:0] b);
    start = 1'b1;
    op_in = op;
    count_in = cnt;
    b_in = b;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; load = 1'b0; op_in = '0; count_in = '0;
    b_in = '0; load_data = '0;
    tick();
    checks++;
    if ({acc, carry, zero, busy, done, alu_b, alu_op} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL reset_state got acc=%h c=%b z=%b busy=%b done=%b b=%h op=%0d", acc, carry, zero, busy, done, alu_b, alu_op);
    end
    rst = 1'b0;
    // Reset mid-RUN must act at once, before any clock edge.
    do_load(8'h81);
    start_op(3'd6, 3'd7, 8'h11);
    tick(); tick(); tick();
    checks++;
    if ({busy, acc} !== {1'b1, 8'h0A}) begin
      errors++;
      $display("FAIL reset_prerun got busy=%b acc=%h exp busy=1 acc=0a", busy, acc);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({acc, carry, zero, busy, done, alu_b, alu_op} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL reset_midrun got acc=%h c=%b z=%b busy=%b done=%b b=%h op=%0d", acc, carry, zero, busy, done, alu_b, alu_op);
    end
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release got busy=%b done=%b exp 00", busy, done);
    end
    do_load(8'h81);
    start_op(3'd6, 3'd0, 8'h00);
    tick();
    checks++;
    if ({acc, carry, zero, done} !== {8'h02, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_restart got acc=%h c=%b z=%b done=%b exp 02 1 0 1", acc, carry, zero, done);
    end
    tick();
  endtask

  task automatic test_single_pass;
    do_reset();
    do_load(8'h81);
    checks++;
    if ({acc, zero, busy} !== {8'h81, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_idle got acc=%h z=%b busy=%b exp 81 0 0", acc, zero, busy);
    end
    start_op(3'd6, 3'd0, 8'h3C);
    checks++;
    if ({busy, done, alu_op, alu_b, acc} !== {1'b1, 1'b0, 3'd6, 8'h3C, 8'h81}) begin
      errors++;
      $display("FAIL single_latch got busy=%b done=%b op=%0d b=%h acc=%h", busy, done, alu_op, alu_b, acc);
    end
    tick();
    checks++;
    if ({acc, carry, zero, busy, done} !== {8'h02, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_pass got acc=%h c=%b z=%b busy=%b done=%b exp 02 1 0 1 1", acc, carry, zero, busy, done);
    end
    tick();
    checks++;
    if ({acc, busy, done} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_end got acc=%h busy=%b done=%b exp 02 0 0", acc, busy, done);
    end
  endtask

  task automatic test_multi_pass(input bit disturb);
    logic [7:0] ea [4];
    logic       ec [4];
    ea = '{8'h02, 8'h05, 8'h0A, 8'h14};
    ec = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    do_load(8'h81);
    start_op(3'd6, 3'd3, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      if (disturb && i == 1) begin
        start = 1'b1; load = 1'b1; load_data = 8'hFF; op_in = 3'd1; b_in = 8'h00; count_in = 3'd7;
      end
      tick();
      start = 1'b0; load = 1'b0;
      checks++;
      if ({acc, carry, busy, done, alu_op, alu_b} !== {ea[i], ec[i], 1'b1, (i == 3), 3'd6, 8'h5A}) begin
        errors++;
        $display("FAIL multi_pass%0d d=%0d got acc=%h c=%b busy=%b done=%b op=%0d b=%h exp acc=%h c=%b",
                 i, disturb, acc, carry, busy, done, alu_op, alu_b, ea[i], ec[i]);
      end
    end
    tick();
    checks++;
    if ({acc, busy, done} !== {8'h14, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL multi_end d=%0d got acc=%h busy=%b done=%b exp 14 0 0", disturb, acc, busy, done);
    end
  endtask

  task automatic test_zero_result;
    do_reset();
    do_load(8'h80);
    start_op(3'd6, 3'd0, 8'h00);
    tick();
    checks++;
    if ({acc, carry, zero, done} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL zero_result got acc=%h c=%b z=%b done=%b exp 00 1 1 1", acc, carry, zero, done);
    end
    tick();
  endtask

  task automatic test_start_load;
    do_reset();
    do_load(8'h81);
    load = 1'b1; load_data = 8'hFF;
    start_op(3'd6, 3'd0, 8'h00);
    load = 1'b0;
    checks++;
    if ({acc, busy} !== {8'h81, 1'b1}) begin
      errors++;
      $display("FAIL start_load_prio got acc=%h busy=%b exp 81 1", acc, busy);
    end
    tick();
    checks++;
    if ({acc, carry, done} !== {8'h02, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL start_load_res got acc=%h c=%b done=%b exp 02 1 1", acc, carry, done);
    end
    tick();
  endtask

  task automatic test_full_count;
    do_reset();
    do_load(8'h01);
    start_op(3'd6, 3'd7, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({busy, done} !== {1'b1, (i == 7)}) begin
        errors++;
        $display("FAIL full_done%0d got busy=%b done=%b exp busy=1 done=%b", i, busy, done, (i == 7));
      end
      if (i == 6) begin
        checks++;
        if ({acc, carry} !== {8'h80, 1'b0}) begin
          errors++;
          $display("FAIL full_pass7 got acc=%h c=%b exp 80 0", acc, carry);
        end
      end
    end
    checks++;
    if ({acc, carry, zero} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL full_result got acc=%h c=%b z=%b exp 00 1 1", acc, carry, zero);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    do_reset();
    do_load(8'h81);
    start_op(3'd6, 3'd0, 8'h00);
    tick();
    // start held through DONE: ignored there, accepted on the following edge.
    start = 1'b1; op_in = 3'd6; count_in = 3'd0; b_in = 8'h77;
    tick();
    checks++;
    if ({busy, done, alu_b} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL b2b_done_ignored got busy=%b done=%b b=%h exp 0 0 00", busy, done, alu_b);
    end
    tick();
    start = 1'b0;
    checks++;
    if ({busy, alu_b} !== {1'b1, 8'h77}) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b b=%h exp 1 77", busy, alu_b);
    end
    tick();
    checks++;
    if ({acc, carry, done} !== {8'h05, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_result got acc=%h c=%b done=%b exp 05 0 1", acc, carry, done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass(1'b0);
    test_multi_pass(1'b1);
    test_zero_result();
    test_start_load();
    test_full_count();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_accum.md
Name: alu_accum

Overview:
- Downstream stage of the 8-bit bitwise ALU slice; owns the accumulator, carry flag and zero flag.
- Captures the slice's result byte and carry-out, and feeds the accumulator back as the slice's A operand.
- Sequences multi-pass operations (e.g. shift/rotate by N) by repeating one latched opcode for count+1 clock cycles, with a start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 8, datapath width of accumulator, operand B and result.
- CNT_W, 3, width of the repeat-count field (max passes = 2^CNT_W).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multi-pass op; accepted only in IDLE.
- op_in  input  3  opcode latched on start, held on alu_op.
- count_in  input  CNT_W  passes minus one, latched on start.
- b_in  input  WIDTH  B operand, latched on start.
- load  input  1  direct accumulator write; honoured only in IDLE.
- load_data  input  WIDTH  value for load.
- res_q  input  WIDTH  result byte from the bitwise slice.
- res_cout  input  1  carry-out from the bitwise slice.
- alu_a  output  WIDTH  equals acc; drives the slice's A input.
- alu_b  output  WIDTH  latched B.
- alu_op  output  3  latched opcode.
- alu_cin  output  1  equals carry.
- acc  output  WIDTH  accumulator.
- carry  output  1  carry flag.
- zero  output  1  high when acc == 0; registered, updated together with acc.
- busy  output  1  high when state != IDLE.
- done  output  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset: asynchronous, active-high; applies immediately on assertion, including mid-operation, and discards the operation.
  - Reset values: state=IDLE, acc=0, carry=0, zero=1, alu_b=0, alu_op=0, remaining=0, busy=0, done=0.
- IDLE, start=1 at edge E:
  - Latch op_in, b_in, remaining=count_in; go to RUN.
  - If load is also high in the same cycle, load is ignored (start has priority).
- IDLE, start=0, load=1: acc<=load_data, zero<=(load_data==0), carry unchanged.
- RUN, every edge:
  - acc<=res_q, carry<=res_cout, zero<=(res_q==0).
  - If remaining==0, go to DONE; otherwise remaining<=remaining-1.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Timing: N = count_in+1 captures occur at edges E+1..E+N; done is high between E+N and E+N+1.
  - A new start is first accepted at edge E+N+2.
- start or load while in RUN or DONE is ignored, with no queuing.
- Latched op and B stay constant for the whole operation, so the slice sees stable control.
- count_in is taken modulo 2^CNT_W; an all-ones value gives 2^CNT_W passes, with no wrap past zero.
- The block adds no combinational path from res_q/res_cout to any output; the loop through the slice is broken by acc/carry.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE (2-bit);
  - the 3-bit opcode field width and named opcodes shared with the slice's decoder.
- One natural sub-module: repeat_counter, a loadable CNT_W down-counter with a zero flag, async active-high reset.

Test Plan:
- Bench stub for the slice: res_q={alu_a[6:0],alu_cin}, res_cout=alu_a[7] (rotate through carry).
- Reset mid-RUN, then release -> acc=0x00, carry=0, zero=1, busy=0, done=0 immediately; next start behaves normally.
- load 0x81 in IDLE; then start with count_in=0 -> one pass, acc=0x02, carry=1, zero=0, done high 1 cycle after capture.
- load 0x81, carry=0; start with count_in=3 -> acc sequence 0x02/c1, 0x05/c0, 0x0A/c0, 0x14/c0; done on cycle E+4; busy high E+1..E+5.
- load 0x80, carry=0; start with count_in=0 -> acc=0x00, carry=1, zero=1.
- start and load together in IDLE (load_data=0xFF) -> load ignored, operation runs on the old acc.
  - start and load pulsed during RUN -> ignored; pass count and result unchanged.
- count_in=7 from acc=0x01, carry=0 -> 8 passes, acc=0x00, carry=1, zero=1; done exactly 8 cycles after start.
